// File: rtl/u_arrtm8_k4_mac_acc_if.sv
// Product-in / frame-sum-out handshake bundle for the truncated-multiplier
// MAC accumulator.
interface u_arrtm8_k4_mac_acc_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/u_arrtm8_k4_mac_acc.sv
// Frame accumulator behind the 8-bit truncated array multiplier (k=4):
// sums up to LEN products, optional saturation, valid/ready result port.
module u_arrtm8_k4_mac_acc #(
  parameter int PROD_W    = 16,
  parameter int TRUNC_LSB = 8,
  parameter int ACC_W     = 24,
  parameter int LEN       = 8,
  parameter bit SAT       = 1'b1,
  localparam int CNT_W    = $clog2(LEN + 1)
) (
  input logic clk,
  input logic rst,
  u_arrtm8_k4_mac_acc_if.slave bus
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [ACC_W-1:0] KEEP =
    ~((ACC_W'(1) << TRUNC_LSB) - ACC_W'(1));

  state_t           state;
  state_t           state_n;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sticky;

  logic             accept;
  logic             last_beat;
  logic [ACC_W-1:0] p;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] nxt;
  logic [CNT_W-1:0] cnt_inc;

  assign bus.in_ready = (state == ACC) || bus.out_ready;
  assign accept  = bus.in_valid && bus.in_ready;
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    p       = ACC_W'(bus.in_prod) & KEEP;
    base    = (cnt == '0) ? '0 : acc;
    sum_ext = {1'b0, base} + {1'b0, p};
    carry   = sum_ext[ACC_W];
    nxt     = sum_ext[ACC_W-1:0];
    // once clamped, a frame stays at the ceiling until it ends
    if (SAT && (carry || sticky)) nxt = KEEP;
    last_beat = accept &&
      ((32'(cnt) + 32'd1 == 32'(LEN)) || bus.in_last);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACC:  if (last_beat) state_n = HOLD;
      HOLD: if (bus.out_ready && !last_beat) state_n = ACC;
      default: state_n = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      sticky        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      bus.out_valid <= (state_n == HOLD);
      if (last_beat) begin
        bus.out_sum   <= nxt;
        bus.out_count <= cnt_inc;
        bus.out_ovf   <= sticky | carry;
        acc           <= '0;
        cnt           <= '0;
        sticky        <= 1'b0;
      end else if (accept) begin
        acc    <= nxt;
        cnt    <= cnt_inc;
        sticky <= sticky | carry;
      end
    end
  end

endmodule

// File: tb/tb_u_arrtm8_k4_mac_acc.sv
// Directed table-driven bench for u_arrtm8_k4_mac_acc, default and
// 17-bit saturating/wrapping builds.
module tb_u_arrtm8_k4_mac_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  u_arrtm8_k4_mac_acc_if #(.PROD_W(16), .ACC_W(24), .CNT_W(4)) if0 ();
  u_arrtm8_k4_mac_acc_if #(.PROD_W(16), .ACC_W(17), .CNT_W(4)) if1 ();
  u_arrtm8_k4_mac_acc_if #(.PROD_W(16), .ACC_W(17), .CNT_W(4)) if2 ();

  u_arrtm8_k4_mac_acc dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  u_arrtm8_k4_mac_acc #(.ACC_W(17), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  u_arrtm8_k4_mac_acc #(.ACC_W(17), .SAT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    string       name;
    logic [15:0] prod;
    logic [15:0] step;
    int          beats;
    logic        last;
    logic [23:0] sum;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [15:0] pr, input logic lst);
    if0.in_valid = 1'b1;
    if0.in_prod  = pr;
    if0.in_last  = lst;
    tick();
    if0.in_valid = 1'b0;
    if0.in_last  = 1'b0;
  endtask

  task automatic beat17(input logic [15:0] pr, input logic lst);
    if1.in_valid = 1'b1; if2.in_valid = 1'b1;
    if1.in_prod  = pr;   if2.in_prod  = pr;
    if1.in_last  = lst;  if2.in_last  = lst;
    tick();
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    if1.in_last  = 1'b0; if2.in_last  = 1'b0;
  endtask

  task automatic drain0();
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    chk("drain_valid", 32'(if0.out_valid), 0);
  endtask

  task automatic run_frame(input vec_t v);
    for (int i = 0; i < v.beats; i++) begin
      if (i == v.beats - 1)
        chk({v.name, "_pre_valid"}, 32'(if0.out_valid), 0);
      chk({v.name, "_in_ready"}, 32'(if0.in_ready), 1);
      beat0(v.prod + 16'(i) * v.step, v.last && (i == v.beats - 1));
    end
    chk({v.name, "_valid"}, 32'(if0.out_valid), 1);
    chk({v.name, "_sum"}, 32'(if0.out_sum), 32'(v.sum));
    chk({v.name, "_count"}, 32'(if0.out_count), 32'(v.cnt));
    chk({v.name, "_ovf"}, 32'(if0.out_ovf), 0);
    chk({v.name, "_lsb"}, 32'(if0.out_sum[7:0]), 0);
    drain0();
  endtask

  initial begin
    vecs[0] = '{"full8_e100", 16'hE100, 16'h0000, 8, 1'b0, 24'h070800, 4'd8};
    vecs[1] = '{"last3", 16'h0100, 16'h0100, 3, 1'b1, 24'h000600, 4'd3};
    vecs[2] = '{"lsb_ign", 16'h01FF, 16'h0000, 8, 1'b0, 24'h000800, 4'd8};
    vecs[3] = '{"one_beat", 16'h1234, 16'h0000, 1, 1'b1, 24'h001200, 4'd1};
    vecs[4] = '{"ramp8", 16'h0100, 16'h0100, 8, 1'b0, 24'h002400, 4'd8};

    {if0.in_valid, if0.in_last, if0.out_ready} = '0;
    {if1.in_valid, if1.in_last, if1.out_ready} = '0;
    {if2.in_valid, if2.in_last, if2.out_ready} = '0;
    if0.in_prod = '0; if1.in_prod = '0; if2.in_prod = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", 32'(if0.out_valid), 0);
    chk("rst_sum", 32'(if0.out_sum), 0);
    chk("rst_count", 32'(if0.out_count), 0);
    chk("rst_ovf", 32'(if0.out_ovf), 0);
    chk("rst_in_ready", 32'(if0.in_ready), 1);

    for (int k = 0; k < 5; k++) run_frame(vecs[k]);

    // stalled result, then drain and accept in the same cycle
    beat0(16'h0100, 1'b0);
    beat0(16'h0100, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if0.in_valid = 1'b1;
      if0.in_prod  = 16'h0300;
      chk("stall_valid", 32'(if0.out_valid), 1);
      chk("stall_sum", 32'(if0.out_sum), 32'h200);
      chk("stall_in_ready", 32'(if0.in_ready), 0);
      tick();
    end
    chk("stall_count", 32'(if0.out_count), 2);
    if0.out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 32'(if0.in_ready), 1);
    tick();
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b0;
    chk("drain_accept_valid", 32'(if0.out_valid), 0);
    beat0(16'h0400, 1'b1);
    chk("next_sum", 32'(if0.out_sum), 32'h700);
    chk("next_count", 32'(if0.out_count), 2);
    // drain plus a 1-beat frame keeps HOLD with the new result
    if0.out_ready = 1'b1;
    beat0(16'h0500, 1'b1);
    if0.out_ready = 1'b0;
    chk("reload_valid", 32'(if0.out_valid), 1);
    chk("reload_sum", 32'(if0.out_sum), 32'h500);
    chk("reload_count", 32'(if0.out_count), 1);
    drain0();

    // reset mid-frame and mid-hold
    for (int b = 0; b < 4; b++) beat0(16'h0100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(if0.out_valid), 0);
    chk("mid_rst_sum", 32'(if0.out_sum), 0);
    chk("mid_rst_count", 32'(if0.out_count), 0);
    for (int b = 0; b < 8; b++) beat0(16'h0100, 1'b0);
    chk("post_rst_sum", 32'(if0.out_sum), 32'h800);
    chk("post_rst_count", 32'(if0.out_count), 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst_valid", 32'(if0.out_valid), 0);
    chk("hold_rst_sum", 32'(if0.out_sum), 0);

    // 17-bit accumulator overflow: saturate vs wrap
    beat17(16'hE100, 1'b0);
    beat17(16'hE100, 1'b0);
    beat17(16'hE100, 1'b1);
    chk("sat_valid", 32'(if1.out_valid), 1);
    chk("sat_sum", 32'(if1.out_sum), 32'h1FF00);
    chk("sat_ovf", 32'(if1.out_ovf), 1);
    chk("sat_count", 32'(if1.out_count), 3);
    chk("wrap_sum", 32'(if2.out_sum), 32'h0A300);
    chk("wrap_ovf", 32'(if2.out_ovf), 1);
    if1.out_ready = 1'b1; if2.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0; if2.out_ready = 1'b0;
    beat17(16'h0100, 1'b0);
    beat17(16'h0100, 1'b1);
    chk("sat_clr_sum", 32'(if1.out_sum), 32'h200);
    chk("sat_clr_ovf", 32'(if1.out_ovf), 0);
    chk("wrap_clr_ovf", 32'(if2.out_ovf), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
